// File: rtl/mul_seq_arb_pkg.sv
// Shared types and constants for the sequenced multiplier
// with two-requester round-robin arbitration.
package mul_seq_pkg;

  localparam int DW_DEF = 8;
  localparam int RW_DEF = DW_DEF + 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0] PH_X1 = 2'd0;
  localparam logic [1:0] PH_X3 = 2'd1;
  localparam logic [1:0] PH_X7 = 2'd2;
  localparam logic [1:0] PH_X8 = 2'd3;

endpackage

// File: rtl/mul_seq_arb_if.sv
// Request and result handshake bundle.
// slave is the multiplier side, master the client side.
interface mul_seq_arb_if #(
  parameter int DW = 8,
  parameter int RW = DW + 3
);

  logic          req0_valid;
  logic [DW-1:0] req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [DW-1:0] req1_data;
  logic          req1_ready;
  logic          res_valid;
  logic          res_ready;
  logic          res_id;
  logic [1:0]    res_phase;
  logic [RW-1:0] res_data;
  logic          busy;

  modport slave (
    input  req0_valid,
    input  req0_data,
    output req0_ready,
    input  req1_valid,
    input  req1_data,
    output req1_ready,
    output res_valid,
    input  res_ready,
    output res_id,
    output res_phase,
    output res_data,
    output busy
  );

  modport master (
    output req0_valid,
    output req0_data,
    input  req0_ready,
    output req1_valid,
    output req1_data,
    input  req1_ready,
    input  res_valid,
    output res_ready,
    input  res_id,
    input  res_phase,
    input  res_data,
    input  busy
  );

endinterface

// File: rtl/mul_shift_unit.sv
// Shift/subtract product of an operand for one beat phase:
// x1, x3, x7, x8, zero-extended to the result width.
module mul_shift_unit
  import mul_seq_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = DW + 3
) (
  input  logic [DW-1:0] operand,
  input  logic [1:0]    phase,
  output logic [RW-1:0] product
);

  logic [RW-1:0] ext;

  assign ext = RW'(operand);

  always_comb begin
    product = '0;
    unique case (phase)
      PH_X1: product = ext;
      PH_X3: product = (ext << 2) - ext;
      PH_X7: product = (ext << 3) - ext;
      PH_X8: product = ext << 3;
    endcase
  end

endmodule

// File: rtl/mul_seq_arb.sv
// Two-requester sequenced multiplier: each accepted operand
// emits four beats (x1, x3, x7, x8) with round-robin grant.
module mul_seq_arb
  import mul_seq_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = DW + 3
) (
  input logic          clk,
  input logic          rst,
  mul_seq_arb_if.slave bus
);

  state_t        state;
  logic [1:0]    phase;
  logic [DW-1:0] opnd;
  logic          id;
  logic          last_id;

  logic          win;
  logic          g0;
  logic          g1;
  logic          acc;
  logic          nxt_id;
  logic [DW-1:0] nxt_d;
  logic [RW-1:0] prod;

  // Accept on idle, or on the final beat being consumed
  always_comb begin
    win = (state == IDLE) ||
          (state == RUN && phase == PH_X8 && bus.res_ready);
    g0 = !rst && win && bus.req0_valid &&
         (!bus.req1_valid || last_id);
    g1 = !rst && win && bus.req1_valid &&
         (!bus.req0_valid || !last_id);
    acc    = g0 || g1;
    nxt_id = g1;
    nxt_d  = g1 ? bus.req1_data : bus.req0_data;
  end

  assign bus.req0_ready = g0;
  assign bus.req1_ready = g1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      phase   <= PH_X1;
      opnd    <= '0;
      id      <= 1'b0;
      last_id <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (acc) begin
            state   <= RUN;
            phase   <= PH_X1;
            opnd    <= nxt_d;
            id      <= nxt_id;
            last_id <= nxt_id;
          end
        end
        RUN: begin
          if (bus.res_ready) begin
            if (phase == PH_X8) begin
              if (acc) begin
                phase   <= PH_X1;
                opnd    <= nxt_d;
                id      <= nxt_id;
                last_id <= nxt_id;
              end else begin
                state <= IDLE;
              end
            end else begin
              phase <= phase + 2'd1;
            end
          end
        end
      endcase
    end
  end

  // Outputs come straight off registers, so they hold in IDLE
  mul_shift_unit #(
    .DW(DW),
    .RW(RW)
  ) u_shift (
    .operand(opnd),
    .phase  (phase),
    .product(prod)
  );

  assign bus.res_valid = (state == RUN);
  assign bus.busy      = (state == RUN);
  assign bus.res_id    = id;
  assign bus.res_phase = phase;
  assign bus.res_data  = prod;

endmodule

// File: tb/tb_mul_seq_arb.sv
// Random and directed checks of mul_seq_arb against a
// transaction-level beat-queue reference model.
module tb_mul_seq_arb;

  typedef struct {
    logic        id;
    logic [1:0]  ph;
    logic [10:0] data;
  } beat_t;

  logic clk;
  logic rst;

  mul_seq_arb_if #(.DW(8), .RW(11)) bus ();

  mul_seq_arb #(
    .DW(8),
    .RW(11)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec;
  int nbad;

  beat_t    q[$];
  beat_t    last_b;
  logic     m_last;
  logic [7:0] src0[$];
  logic [7:0] src1[$];
  logic     acc_log[$];
  logic     gap0;
  logic     gap1;
  logic     rr;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic void push_op(logic id, logic [7:0] d);
    int m[4] = '{1, 3, 7, 8};
    for (int i = 0; i < 4; i++) begin
      beat_t b;
      b.id   = id;
      b.ph   = 2'(i);
      b.data = 11'(int'(d) * m[i]);
      q.push_back(b);
    end
  endfunction

  function automatic void model_reset();
    q.delete();
    last_b = '{id: 1'b0, ph: 2'd0, data: 11'd0};
    m_last = 1'b1;
  endfunction

  task automatic step();
    beat_t e;
    logic  ev;
    logic  v0;
    logic  v1;
    logic  win;
    logic  g0;
    logic  g1;
    @(negedge clk);
    v0 = (src0.size() > 0) && !gap0;
    v1 = (src1.size() > 0) && !gap1;
    bus.req0_valid = v0;
    bus.req1_valid = v1;
    bus.req0_data  = (src0.size() > 0) ? src0[0] : 8'($urandom);
    bus.req1_data  = (src1.size() > 0) ? src1[0] : 8'($urandom);
    bus.res_ready  = rr;
    #1;
    ev = (q.size() != 0);
    e  = ev ? q[0] : last_b;
    chk("res_valid", 32'(bus.res_valid), 32'(ev));
    chk("busy", 32'(bus.busy), 32'(ev));
    chk("res_id", 32'(bus.res_id), 32'(e.id));
    chk("res_phase", 32'(bus.res_phase), 32'(e.ph));
    chk("res_data", 32'(bus.res_data), 32'(e.data));
    win = (q.size() == 0) || (q.size() == 1 && rr);
    g0  = win && v0 && (!v1 || m_last);
    g1  = win && v1 && (!v0 || !m_last);
    chk("req0_ready", 32'(bus.req0_ready), 32'(g0));
    chk("req1_ready", 32'(bus.req1_ready), 32'(g1));
    if (ev && rr) last_b = q.pop_front();
    if (g0) begin
      push_op(1'b0, src0.pop_front());
      m_last = 1'b0;
      acc_log.push_back(1'b0);
    end
    if (g1) begin
      push_op(1'b1, src1.pop_front());
      m_last = 1'b1;
      acc_log.push_back(1'b1);
    end
  endtask

  task automatic rst_chk(string tag);
    chk({tag, "_valid"}, 32'(bus.res_valid), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_data"}, 32'(bus.res_data), 32'd0);
    chk({tag, "_id"}, 32'(bus.res_id), 32'd0);
    chk({tag, "_phase"}, 32'(bus.res_phase), 32'd0);
    chk({tag, "_rdy0"}, 32'(bus.req0_ready), 32'd0);
    chk({tag, "_rdy1"}, 32'(bus.req1_ready), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    rst_chk("rst_now");
    model_reset();
    src0.delete();
    src1.delete();
    @(negedge clk);
    #1;
    rst_chk("rst_hold");
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    nvec = 0;
    nbad = 0;
    rst  = 1'b1;
    gap0 = 1'b0;
    gap1 = 1'b0;
    rr   = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_data  = 8'd0;
    bus.req1_data  = 8'd0;
    bus.res_ready  = 1'b1;
    model_reset();
    do_reset();

    // single request, then max operand
    src0.push_back(8'd5);
    run(7);
    src0.push_back(8'hFF);
    run(7);

    // contention from reset
    do_reset();
    src0.push_back(8'd3);
    src1.push_back(8'd4);
    run(11);

    // backpressure during phase1 of d=10
    src0.push_back(8'd10);
    run(2);
    src1.push_back(8'd9);
    rr = 1'b0;
    run(3);
    rr = 1'b1;
    run(8);

    // reset mid-run during phase2 of d=6
    src0.push_back(8'd6);
    run(3);
    do_reset();
    src1.push_back(8'd2);
    run(7);

    // fairness
    do_reset();
    acc_log.delete();
    for (int i = 0; i < 4; i++) begin
      src0.push_back(8'(8'd20 + 8'(i)));
      src1.push_back(8'(8'd40 + 8'(i)));
    end
    run(40);
    chk("fair_cnt", 32'(acc_log.size()), 32'd8);
    for (int i = 0; i < acc_log.size() && i < 8; i++)
      chk("fair_id", 32'(acc_log[i]), 32'(i % 2));

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0 && src0.size() < 3)
        src0.push_back(($urandom_range(0, 9) == 0) ?
                       8'hFF : 8'($urandom));
      if ($urandom_range(0, 3) == 0 && src1.size() < 3)
        src1.push_back(($urandom_range(0, 9) == 0) ?
                       8'h00 : 8'($urandom));
      gap0 = ($urandom_range(0, 4) == 0);
      gap1 = ($urandom_range(0, 4) == 0);
      rr   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      step();
    end
    gap0 = 1'b0;
    gap1 = 1'b0;
    rr   = 1'b1;
    run(40);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule
